// File: rtl/simon_axi_pkg.sv
// Shared AXI encodings and FSM state type for the SIMON egress write path.
package simon_axi_pkg;
   localparam int BEAT_BYTES = 16;
   localparam int BEATS_W    = 9;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
   localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_DONE
   } wr_state_t;
endpackage

// File: rtl/simon_fifo_to_axi_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the egress writer and memory.
interface simon_fifo_to_axi_wr_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int LEN_W  = 8
);
   logic [ADDR_W-1:0]   awaddr;
   logic [LEN_W-1:0]    awlen;
   logic [1:0]          awburst;
   logic [3:0]          awcache;
   logic                awlock;
   logic [2:0]          awprot;
   logic [3:0]          awqos;
   logic [3:0]          awregion;
   logic [2:0]          awsize;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awaddr, awlen, awburst, awcache, awlock, awprot,
      output awqos, awregion, awsize, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awlen, awburst, awcache, awlock, awprot,
      input  awqos, awregion, awsize, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/simon_axi_burst_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST_LEN, beats left in 4KB page).
module simon_axi_burst_calc
   import simon_axi_pkg::*;
#(
   parameter int CNT_WIDTH     = 20,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic [7:0]           addr_blk,
   input  logic [CNT_WIDTH-1:0] remaining,
   output logic [BEATS_W-1:0]   beats
);
   logic [BEATS_W-1:0]   cap;
   logic [CNT_WIDTH-1:0] cap_ext;

   always_comb begin
      // addr_blk is addr[11:4]; 256 beats per 4KB page
      cap = 9'd256 - {1'b0, addr_blk};
      if (cap > BEATS_W'(MAX_BURST_LEN))
         cap = BEATS_W'(MAX_BURST_LEN);
      cap_ext = CNT_WIDTH'(cap);
      beats = (remaining < cap_ext) ? remaining[BEATS_W-1:0] : cap;
   end
endmodule

// File: rtl/simon_fifo_to_axi_wr.sv
// Drains egress FIFO blocks into AXI4 INCR write bursts; one burst in flight.
// Define SIMON_WR_BRESP_CHECK_EN to stop the job and flag status_err on a bad BRESP.
module simon_fifo_to_axi_wr
   import simon_axi_pkg::*;
#(
   parameter int DATA_DATA_WIDTH = 128,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int DATA_LEN_WIDTH  = 8,
   parameter int MAX_BURST_LEN   = 16,
   parameter int CNT_WIDTH       = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_start,
   input  logic [DATA_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [CNT_WIDTH-1:0]       cfg_num_blocks,
   output logic                       status_busy,
   output logic                       status_done,
   output logic                       status_err,
   input  logic [DATA_DATA_WIDTH-1:0] egress_fifo_din,
   input  logic                       egress_fifo_vld,
   output logic                       egress_fifo_rdy,
   simon_fifo_to_axi_wr_if.master     simon_block_out
);
   wr_state_t                  state_q, state_d;
   logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]       rem_q, rem_d, rem_next;
   logic [BEATS_W-1:0]         beat_q, beat_d;
   logic [BEATS_W-1:0]         beats, beats_m1;
   logic                       w_fire, last_beat;

   simon_axi_burst_calc #(
      .CNT_WIDTH     (CNT_WIDTH),
      .MAX_BURST_LEN (MAX_BURST_LEN)
   ) u_calc (
      .addr_blk  (addr_q[11:4]),
      .remaining (rem_q),
      .beats     (beats)
   );

   assign beats_m1  = beats - BEATS_W'(1);
   assign last_beat = (beat_q == beats_m1);
   assign rem_next  = rem_q - CNT_WIDTH'(beats);
   assign w_fire    = (state_q == ST_DATA) & egress_fifo_vld
                    & simon_block_out.wready;

`ifdef SIMON_WR_BRESP_CHECK_EN
   logic err_q, err_d;
   logic resp_err;
   assign resp_err   = (simon_block_out.bresp != AXI_RESP_OKAY);
   assign status_err = err_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^simon_block_out.bresp;
   assign status_err   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
`ifdef SIMON_WR_BRESP_CHECK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         ST_IDLE: if (cfg_start) begin
            addr_d  = cfg_base_addr & ~DATA_ADDR_WIDTH'(BEAT_BYTES - 1);
            rem_d   = cfg_num_blocks;
`ifdef SIMON_WR_BRESP_CHECK_EN
            err_d   = 1'b0;
`endif
            state_d = (cfg_num_blocks == '0) ? ST_DONE : ST_ADDR;
         end
         ST_ADDR: if (simon_block_out.awready) begin
            beat_d  = '0;
            state_d = ST_DATA;
         end
         ST_DATA: if (w_fire) begin
            beat_d = beat_q + BEATS_W'(1);
            if (last_beat)
               state_d = ST_RESP;
         end
         ST_RESP: if (simon_block_out.bvalid) begin
            addr_d  = addr_q + DATA_ADDR_WIDTH'({beats, 4'b0000});
            rem_d   = rem_next;
            state_d = (rem_next == '0) ? ST_DONE : ST_ADDR;
`ifdef SIMON_WR_BRESP_CHECK_EN
            if (resp_err) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
`ifdef SIMON_WR_BRESP_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
`ifdef SIMON_WR_BRESP_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign status_busy     = (state_q != ST_IDLE);
   assign status_done     = (state_q == ST_DONE);
   assign egress_fifo_rdy = (state_q == ST_DATA) & simon_block_out.wready;

   assign simon_block_out.awaddr   = addr_q;
   assign simon_block_out.awlen    = DATA_LEN_WIDTH'(beats_m1);
   assign simon_block_out.awburst  = AXI_BURST_INCR;
   assign simon_block_out.awcache  = AXI_CACHE_DEF;
   assign simon_block_out.awlock   = 1'b0;
   assign simon_block_out.awprot   = 3'b000;
   assign simon_block_out.awqos    = 4'b0000;
   assign simon_block_out.awregion = 4'b0000;
   assign simon_block_out.awsize   = AXI_SIZE_16B;
   assign simon_block_out.awvalid  = (state_q == ST_ADDR);
   assign simon_block_out.wdata    = egress_fifo_din;
   assign simon_block_out.wstrb    = '1;
   assign simon_block_out.wlast    = (state_q == ST_DATA) & last_beat;
   assign simon_block_out.wvalid   = (state_q == ST_DATA) & egress_fifo_vld;
   assign simon_block_out.bready   = (state_q == ST_RESP);
endmodule
